gdb_rsp_rx: RTL and testbench

//   GDB Remote Serial Protocol receive framer for the simulation debug bridge. It consumes the raw

---
 rtl/gdb_rsp_rx_if.sv | 41 ++++
 rtl/gdb_rsp_rx.sv | 183 ++++++++++++++++++
 tb/tb_gdb_rsp_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gdb_rsp_rx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gdb_rsp_rx_if : socket byte, ack byte and payload streams of the RSP framer |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
interface gdb_rsp_rx_if #(
  parameter int BUF_LEN = 512
);
  localparam int LEN_W = $clog2(BUF_LEN + 1);

  logic             rx_vld;
  logic             rx_rdy;
  logic [7:0]       rx_dat;
  logic             noack;
  logic             ack_vld;
  logic             ack_rdy;
  logic [7:0]       ack_dat;
  logic             pkt_vld;
  logic             pkt_rdy;
  logic [7:0]       pkt_dat;
  logic             pkt_lst;
  logic [LEN_W-1:0] pkt_len;
  logic             brk;
  logic             err_chk;
  logic             err_ovf;

  // Framer side.
  modport master (
    input  rx_vld, rx_dat, noack, ack_rdy, pkt_rdy,
    output rx_rdy, ack_vld, ack_dat, pkt_vld, pkt_dat, pkt_lst, pkt_len,
           brk, err_chk, err_ovf
  );

  // Socket server / command decoder side.
  modport slave (
    output rx_vld, rx_dat, noack, ack_rdy, pkt_rdy,
    input  rx_rdy, ack_vld, ack_dat, pkt_vld, pkt_dat, pkt_lst, pkt_len,
           brk, err_chk, err_ovf
  );
endinterface
`default_nettype wire

// File: rtl/gdb_rsp_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gdb_rsp_rx : GDB RSP receive framer - checksum, '}' unescape, ack, break     |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module gdb_rsp_rx #(
  parameter int BUF_LEN = 512
) (
  input  logic         clk,
  input  logic         rst,
  gdb_rsp_rx_if.master bus
);
  localparam int LEN_W = $clog2(BUF_LEN + 1);
  localparam int AW    = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;

  typedef enum logic [2:0] {IDLE, DATA, ESC, CHK1, CHK2, ACK, SEND} state_e;

  state_e           state_q;
  logic             rx_rdy_q, ack_vld_q, pkt_vld_q, pkt_lst_q;
  logic             brk_q, err_chk_q, err_ovf_q, ovf_q, bad_q, ok_q;
  logic [7:0]       ack_dat_q, sum_q, rdat_q;
  logic [3:0]       hi_q;
  logic [LEN_W-1:0] cnt_q, rd_q;
  logic [7:0]       mem_q [BUF_LEN];

  logic             rx_fire, store, mem_we, mem_re, hex_ok, chk_ok;
  logic [3:0]       hex_nib;
  logic [7:0]       mem_wdat;
  logic [AW-1:0]    mem_addr;
  logic [LEN_W-1:0] rd_nxt;

  assign rx_fire = bus.rx_vld && rx_rdy_q;
  assign rd_nxt  = rd_q + LEN_W'(1);

  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = 4'd0;
    if (bus.rx_dat >= 8'h30 && bus.rx_dat <= 8'h39)
      hex_nib = bus.rx_dat[3:0];
    else if ((bus.rx_dat >= 8'h61 && bus.rx_dat <= 8'h66) ||
             (bus.rx_dat >= 8'h41 && bus.rx_dat <= 8'h46))
      hex_nib = bus.rx_dat[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  assign chk_ok = !ovf_q && !bad_q && hex_ok && ({hi_q, hex_nib} == sum_q);

  // Single-port buffer: writes only while receiving, reads only while sending.
  always_comb begin
    store = rx_fire && (state_q == ESC ||
            (state_q == DATA && bus.rx_dat != 8'h23 && bus.rx_dat != 8'h24 &&
             bus.rx_dat != 8'h7D));
    mem_we   = store && (cnt_q != LEN_W'(BUF_LEN));
    mem_wdat = (state_q == ESC) ? (bus.rx_dat ^ 8'h20) : bus.rx_dat;
    mem_re   = (state_q == SEND) && (!pkt_vld_q || (bus.pkt_rdy && !pkt_lst_q));
    if (state_q == SEND)
      mem_addr = pkt_vld_q ? rd_nxt[AW-1:0] : '0;
    else
      mem_addr = cnt_q[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdat;
    if (mem_re) rdat_q <= mem_q[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_rdy_q  <= 1'b0;
      ack_vld_q <= 1'b0;
      ack_dat_q <= 8'h00;
      pkt_vld_q <= 1'b0;
      pkt_lst_q <= 1'b0;
      brk_q     <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      ok_q      <= 1'b0;
      sum_q     <= 8'h00;
      hi_q      <= 4'd0;
      cnt_q     <= '0;
      rd_q      <= '0;
    end else begin
      brk_q     <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rx_rdy_q <= 1'b1;
          if (rx_fire) begin
            if (bus.rx_dat == 8'h24) begin
              state_q <= DATA;
              sum_q   <= 8'h00;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              bad_q   <= 1'b0;
            end else if (bus.rx_dat == 8'h03) begin
              brk_q <= 1'b1;
            end
          end
        end
        DATA: if (rx_fire) begin
          if (bus.rx_dat == 8'h23) begin
            state_q <= CHK1;
          end else if (bus.rx_dat == 8'h24) begin
            sum_q <= 8'h00;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
          end else begin
            if (bus.rx_dat == 8'h7D) state_q <= ESC;
            sum_q <= sum_q + bus.rx_dat;
          end
        end
        ESC: if (rx_fire) begin
          sum_q   <= sum_q + bus.rx_dat;
          state_q <= DATA;
        end
        CHK1: if (rx_fire) begin
          hi_q    <= hex_nib;
          bad_q   <= bad_q || !hex_ok;
          state_q <= CHK2;
        end
        CHK2: if (rx_fire) begin
          state_q   <= ACK;
          rx_rdy_q  <= 1'b0;
          ok_q      <= chk_ok;
          ack_vld_q <= !bus.noack;
          ack_dat_q <= chk_ok ? 8'h2B : 8'h2D;
          err_ovf_q <= ovf_q;
          err_chk_q <= !ovf_q && !chk_ok;
        end
        ACK: if (!ack_vld_q || bus.ack_rdy) begin
          ack_vld_q <= 1'b0;
          if (ok_q && cnt_q != '0) begin
            state_q <= SEND;
          end else begin
            state_q  <= IDLE;
            rx_rdy_q <= 1'b1;
          end
        end
        SEND: begin
          if (!pkt_vld_q) begin
            pkt_vld_q <= 1'b1;
            pkt_lst_q <= (cnt_q == LEN_W'(1));
            rd_q      <= '0;
          end else if (bus.pkt_rdy) begin
            if (pkt_lst_q) begin
              pkt_vld_q <= 1'b0;
              pkt_lst_q <= 1'b0;
              state_q   <= IDLE;
              rx_rdy_q  <= 1'b1;
            end else begin
              rd_q      <= rd_nxt;
              pkt_lst_q <= (rd_nxt + LEN_W'(1) == cnt_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // A store into a full buffer is dropped but poisons the packet.
      if (store) begin
        if (mem_we) cnt_q <= cnt_q + LEN_W'(1);
        else        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.rx_rdy  = rx_rdy_q;
  assign bus.ack_vld = ack_vld_q;
  assign bus.ack_dat = ack_dat_q;
  assign bus.pkt_vld = pkt_vld_q;
  assign bus.pkt_dat = rdat_q;
  assign bus.pkt_lst = pkt_lst_q;
  assign bus.pkt_len = cnt_q;
  assign bus.brk     = brk_q;
  assign bus.err_chk = err_chk_q;
  assign bus.err_ovf = err_ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_gdb_rsp_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_gdb_rsp_rx : directed vector bench for gdb_rsp_rx (BUF_LEN 512 and 4)      |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module tb_gdb_rsp_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel, rx_vld, noack, ack_rdy, pkt_rdy, stall;
  logic [7:0] rx_dat;

  gdb_rsp_rx_if #(.BUF_LEN(512)) b0 ();
  gdb_rsp_rx_if #(.BUF_LEN(4))   b4 ();

  gdb_rsp_rx #(.BUF_LEN(512)) dut  (.clk(clk), .rst(rst), .bus(b0));
  gdb_rsp_rx #(.BUF_LEN(4))   dut4 (.clk(clk), .rst(rst), .bus(b4));

  // sel picks which instance sees the byte stream and is observed.
  assign b0.rx_vld  = rx_vld && !sel;
  assign b4.rx_vld  = rx_vld && sel;
  assign b0.rx_dat  = rx_dat;
  assign b4.rx_dat  = rx_dat;
  assign b0.noack   = noack;
  assign b4.noack   = noack;
  assign b0.ack_rdy = ack_rdy;
  assign b4.ack_rdy = ack_rdy;
  assign b0.pkt_rdy = pkt_rdy;
  assign b4.pkt_rdy = pkt_rdy;

  logic       m_rx_rdy, m_ack_vld, m_pkt_vld, m_pkt_lst, m_brk, m_chk, m_ovf;
  logic [7:0] m_ack_dat, m_pkt_dat;
  logic [9:0] m_pkt_len;
  assign m_rx_rdy  = sel ? b4.rx_rdy  : b0.rx_rdy;
  assign m_ack_vld = sel ? b4.ack_vld : b0.ack_vld;
  assign m_ack_dat = sel ? b4.ack_dat : b0.ack_dat;
  assign m_pkt_vld = sel ? b4.pkt_vld : b0.pkt_vld;
  assign m_pkt_dat = sel ? b4.pkt_dat : b0.pkt_dat;
  assign m_pkt_lst = sel ? b4.pkt_lst : b0.pkt_lst;
  assign m_pkt_len = sel ? {7'd0, b4.pkt_len} : b0.pkt_len;
  assign m_brk     = sel ? b4.brk     : b0.brk;
  assign m_chk     = sel ? b4.err_chk : b0.err_chk;
  assign m_ovf     = sel ? b4.err_ovf : b0.err_ovf;

  typedef struct {
    string name;
    string stim;
    bit    sel;
    bit    noack;
    bit    stall;
    int    ack;
    string pay;
    int    chk;
    int    ovf;
    int    brk;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic       lst;
    int         len;
    int         cyc;
  } xfer_t;

  vec_t  vecs[$];
  xfer_t xfers[$];
  int    acks[$];
  int    ack_cycs[$];
  int    cyc = 0, n_chk = 0, n_ovf = 0, n_brk = 0, n_stab = 0;
  int    nvec = 0, nerr = 0;

  function automatic vec_t mk(string name, string stim, bit s, bit na, bit st,
                              int ack, string pay, int chk, int ovf, int brk);
    vec_t v;
    v.name = name; v.stim = stim; v.sel = s; v.noack = na; v.stall = st;
    v.ack = ack; v.pay = pay; v.chk = chk; v.ovf = ovf; v.brk = brk;
    return v;
  endfunction

  task automatic check_i(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_s(input string name, input string got, input string exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got '%s' expected '%s'", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    rx_dat = b;
    rx_vld = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (m_rx_rdy) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) timeout("rx_rdy");
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    rx_vld = 1'b0;
  endtask

  task automatic settle();
    bit done = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 400 && !done; i++) begin
      if (m_rx_rdy) done = 1;
      else @(negedge clk);
    end
    if (!done) timeout("settle");
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int    a0, x0, c0, o0, k0, s0, gack, glst, nlst, glen, el;
    string gp, ep;
    sel = v.sel; noack = v.noack; stall = v.stall;
    @(posedge clk); #1;
    a0 = acks.size(); x0 = xfers.size();
    c0 = n_chk; o0 = n_ovf; k0 = n_brk; s0 = n_stab;
    send_str(v.stim);
    settle();
    stall = 1'b0;
    gack = (acks.size() == a0) ? 0 : ((acks.size() == a0 + 1) ? acks[a0] : 999);
    gp = ""; ep = ""; glst = -1; nlst = 0; glen = -1;
    for (int i = x0; i < xfers.size(); i++) begin
      gp = {gp, $sformatf("%02x", xfers[i].dat)};
      if (xfers[i].lst) begin
        nlst++;
        if (glst < 0) glst = i - x0;
      end
      if (i == x0) glen = xfers[i].len;
      else if (xfers[i].len != glen) glen = -2;
    end
    for (int i = 0; i < v.pay.len(); i++) ep = {ep, $sformatf("%02x", v.pay[i])};
    el = v.pay.len();
    check_i({v.name, ".ack"}, gack, v.ack);
    check_s({v.name, ".payload"}, gp, ep);
    check_i({v.name, ".lst_pos"}, glst, el - 1);
    check_i({v.name, ".lst_cnt"}, nlst, (el > 0) ? 1 : 0);
    check_i({v.name, ".len"}, glen, (el > 0) ? el : -1);
    check_i({v.name, ".err_chk"}, n_chk - c0, v.chk);
    check_i({v.name, ".err_ovf"}, n_ovf - o0, v.ovf);
    check_i({v.name, ".brk"}, n_brk - k0, v.brk);
    check_i({v.name, ".stable"}, n_stab - s0, 0);
    if (gack != 0 && xfers.size() > x0)
      check_i({v.name, ".ack_first"}, int'(ack_cycs[a0] < xfers[x0].cyc), 1);
  endtask

  initial begin
    sel = 1'b0; rx_vld = 1'b0; rx_dat = 8'h00; noack = 1'b0;
    ack_rdy = 1'b1; pkt_rdy = 1'b1; stall = 1'b0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (stall) begin
          ack_rdy = !ack_rdy;
          pkt_rdy = !pkt_rdy;
        end else begin
          ack_rdy = 1'b1;
          pkt_rdy = 1'b1;
        end
      end
      // Observer: samples on the falling edge, between active edges.
      begin
        logic       p_vld = 1'b0, p_rdy = 1'b0, p_lst = 1'b0;
        logic [7:0] p_dat = 8'h00;
        xfer_t      x;
        forever begin
          @(negedge clk);
          cyc++;
          if (m_ack_vld && ack_rdy) begin
            acks.push_back(int'(m_ack_dat));
            ack_cycs.push_back(cyc);
          end
          if (m_pkt_vld && pkt_rdy) begin
            x.dat = m_pkt_dat; x.lst = m_pkt_lst; x.len = int'(m_pkt_len); x.cyc = cyc;
            xfers.push_back(x);
          end
          if (p_vld && !p_rdy && (!m_pkt_vld || m_pkt_dat != p_dat || m_pkt_lst != p_lst))
            n_stab++;
          p_vld = m_pkt_vld; p_rdy = pkt_rdy; p_dat = m_pkt_dat; p_lst = m_pkt_lst;
          n_chk += int'(m_chk);
          n_ovf += int'(m_ovf);
          n_brk += int'(m_brk);
        end
      end
    join_none

    vecs.push_back(mk("g_ok",      "$g#67",       0, 0, 0, 8'h2B, "g",    0, 0, 0));
    vecs.push_back(mk("m04_stall", "$m0,4#fd",    0, 0, 1, 8'h2B, "m0,4", 0, 0, 0));
    vecs.push_back(mk("bad_sum",   "$g#00",       0, 0, 0, 8'h2D, "",     1, 0, 0));
    vecs.push_back(mk("after_bad", "$g#67",       0, 0, 0, 8'h2B, "g",    0, 0, 0));
    vecs.push_back(mk("escape",    "$}]#da",      0, 0, 0, 8'h2B, "}",    0, 0, 0));
    vecs.push_back(mk("nonhex",    "$ab#zz",      0, 0, 0, 8'h2D, "",     1, 0, 0));
    vecs.push_back(mk("upper_hex", "$m0,4#FD",    0, 0, 0, 8'h2B, "m0,4", 0, 0, 0));
    vecs.push_back(mk("empty",     "$#00",        0, 0, 0, 8'h2B, "",     0, 0, 0));
    vecs.push_back(mk("break",     "\003",        0, 0, 0, 0,     "",     0, 0, 1));
    vecs.push_back(mk("noise",     "+-x",         0, 0, 0, 0,     "",     0, 0, 0));
    vecs.push_back(mk("noack",     "$g#67",       0, 1, 0, 0,     "g",    0, 0, 0));
    vecs.push_back(mk("resync",    "$ab$g#67",    0, 0, 0, 8'h2B, "g",    0, 0, 0));
    vecs.push_back(mk("data_03",   "$\003#03",    0, 0, 0, 8'h2B, "\003", 0, 0, 0));
    vecs.push_back(mk("wrap_esc",  "$}}}}#f4",    0, 0, 1, 8'h2B, "]]",   0, 0, 0));
    vecs.push_back(mk("ovf4",      "$abcde#f5",   1, 0, 0, 8'h2D, "",     0, 1, 0));
    vecs.push_back(mk("fit4",      "$abcd#8a",    1, 0, 0, 8'h2B, "abcd", 0, 0, 0));

    repeat (3) @(negedge clk);
    check_i("rst.rx_rdy",  int'(m_rx_rdy),  0);
    check_i("rst.ack_vld", int'(m_ack_vld), 0);
    check_i("rst.pkt_vld", int'(m_pkt_vld), 0);
    check_i("rst.pkt_lst", int'(m_pkt_lst), 0);
    check_i("rst.pkt_len", int'(m_pkt_len), 0);
    check_i("rst.pulses",  int'({m_brk, m_chk, m_ovf}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_i("rst.rx_rdy_after", int'(m_rx_rdy), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a packet drops it without any ack.
    begin
      int a0, x0, c0;
      sel = 1'b0; noack = 1'b0;
      a0 = acks.size(); x0 = xfers.size(); c0 = n_chk + n_ovf;
      send_str("$ab");
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_i("midrst.acks",   acks.size() - a0, 0);
      check_i("midrst.pkts",   xfers.size() - x0, 0);
      check_i("midrst.errs",   n_chk + n_ovf - c0, 0);
      check_i("midrst.rx_rdy", int'(m_rx_rdy), 1);
      run_vec(mk("post_rst", "$g#67", 0, 0, 0, 8'h2B, "g", 0, 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
